status_reporter: RTL



---
 rtl/bus_msg_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/status_reporter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_msg_pkg.sv
// Shared definitions for per-address bus message slaves: command bits, flag bits,
// message header layout and the slave state encoding.
package bus_msg_pkg;

    // Command byte bit positions
    localparam int unsigned CMD_SNAP  = 0;
    localparam int unsigned CMD_AUTO  = 1;
    localparam int unsigned CMD_ABORT = 7;

    // Flags byte bit positions
    localparam int unsigned FLG_CHG   = 0;
    localparam int unsigned FLG_OVR   = 1;
    localparam int unsigned FLG_AUTO  = 2;

    // Header byte offsets within a message
    localparam int unsigned OFS_SEQ   = 0;
    localparam int unsigned OFS_FLAGS = 1;
    localparam int unsigned OFS_DATA  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    // Flags byte payload; last member is bit 0
    typedef struct packed {
        logic [4:0] rsvd;
        logic       auto_en;
        logic       overrun;
        logic       chg;
    } flags_t;

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/status_reporter.sv
// Bus slave that snapshots board status on host command or status change and
// serves it as a fixed-length framed message, one byte per read request.
module status_reporter
    import bus_msg_pkg::*;
#(
    parameter int unsigned STATUS_W = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [7:0]          master_data,
    input  logic                valid,
    input  logic                rdreq,
    input  logic [STATUS_W-1:0] status_in,
    output logic                have_msg,
    output logic [7:0]          slave_data,
    output logic [7:0]          len
);

    localparam int unsigned NBYTES  = STATUS_W / 8;
    localparam int unsigned MSG_LEN = OFS_DATA + NBYTES;
    localparam int unsigned PTR_W   = $clog2(MSG_LEN);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [7:0]           r_buf     [MSG_LEN];
    logic [7:0]           w_buf_nxt [MSG_LEN];
    logic [7:0]           r_seq;
    logic                 r_auto;
    logic                 r_pend;
    logic                 r_pchg;
    logic                 r_ovr;
    logic                 r_load_chg;
    logic [STATUS_W-1:0]  r_last;
    logic [STATUS_W-1:0]  r_st_prev;
    logic                 r_have_msg;
    logic [7:0]           r_slave_data;
    logic [7:0]           r_len;

    logic [STATUS_W-1:0]  w_st_s;
    logic                 w_snap;
    logic                 w_abort;
    logic                 w_idle_chg;
    logic                 w_send_chg;
    logic                 w_last_rd;
    logic                 w_trig;
    logic                 w_trig_chg;
    logic                 w_pend_eff;
    logic                 w_pchg_eff;
    logic                 w_drop;
    flags_t               w_flags;
    logic                 w_have_nxt;
    logic [7:0]           w_data_nxt;
    logic [7:0]           w_len_nxt;
    logic                 w_unused;

    sync_2ff #(.WIDTH(STATUS_W)) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .i_d   (status_in),
        .o_q   (w_st_s)
    );

    // Command decode and trigger qualification; a busy-time change is an edge, idle uses the level
    assign w_snap     = valid & master_data[CMD_SNAP];
    assign w_abort    = valid & master_data[CMD_ABORT];
    assign w_idle_chg = r_auto & (w_st_s != r_last);
    assign w_send_chg = r_auto & (w_st_s != r_st_prev);
    assign w_last_rd  = (r_state == ST_SEND) & rdreq & (r_ptr == PTR_W'(MSG_LEN - 1));
    assign w_trig     = ((r_state == ST_LOAD) & w_snap) |
                        ((r_state == ST_SEND) & (w_snap | w_send_chg));
    assign w_trig_chg = (r_state == ST_SEND) & w_send_chg;
    assign w_pend_eff = r_pend | w_trig;
    assign w_pchg_eff = r_pend ? r_pchg : w_trig_chg;
    assign w_drop     = w_trig & r_pend;
    assign w_unused   = ^master_data[6:2];

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_snap | w_idle_chg) w_state_nxt = ST_LOAD;
                ST_LOAD: w_state_nxt = ST_SEND;
                ST_SEND: if (w_last_rd) w_state_nxt = w_pend_eff ? ST_LOAD : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next buffer/pointer and the output values they produce after the edge
    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) begin
            w_buf_nxt[i] = r_buf[i];
        end
        w_ptr_nxt       = r_ptr;
        w_flags         = '0;
        w_flags.auto_en = r_auto;
        w_flags.overrun = r_ovr;
        w_flags.chg     = r_load_chg;
        if (w_abort) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                w_buf_nxt[i] = 8'h00;
            end
            w_ptr_nxt = '0;
        end else if (r_state == ST_LOAD) begin
            w_buf_nxt[OFS_SEQ]   = r_seq;
            w_buf_nxt[OFS_FLAGS] = w_flags;
            for (int i = 0; i < NBYTES; i++) begin
                w_buf_nxt[OFS_DATA + i] = w_st_s[8*i +: 8];
            end
            w_ptr_nxt = '0;
        end else if ((r_state == ST_SEND) && rdreq) begin
            w_ptr_nxt = w_last_rd ? '0 : r_ptr + PTR_W'(1);
        end
        w_have_nxt = (w_state_nxt == ST_SEND);
        w_data_nxt = w_have_nxt ? w_buf_nxt[w_ptr_nxt] : 8'h00;
        w_len_nxt  = w_have_nxt ? (8'(MSG_LEN) - 8'(w_ptr_nxt)) : 8'h00;
    end

    // Control registers: auto-enable, pending/overrun bookkeeping, sequence, last report
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_seq      <= '0;
            r_auto     <= 1'b0;
            r_pend     <= 1'b0;
            r_pchg     <= 1'b0;
            r_ovr      <= 1'b0;
            r_load_chg <= 1'b0;
            r_last     <= '0;
            r_st_prev  <= '0;
        end else begin
            r_st_prev <= w_st_s;
            if (valid) r_auto <= master_data[CMD_AUTO];
            if (w_abort) begin
                r_pend <= 1'b0;
                r_pchg <= 1'b0;
                r_ovr  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_load_chg <= w_idle_chg;
                    ST_LOAD: begin
                        r_last <= w_st_s;
                        r_seq  <= r_seq + 8'd1;
                        r_ovr  <= w_drop;
                        r_pend <= w_pend_eff;
                        r_pchg <= w_pchg_eff;
                    end
                    ST_SEND: begin
                        if (w_drop) r_ovr <= 1'b1;
                        if (w_last_rd && w_pend_eff) begin
                            r_load_chg <= w_pchg_eff;
                            r_pend     <= 1'b0;
                            r_pchg     <= 1'b0;
                        end else begin
                            r_pend <= w_pend_eff;
                            r_pchg <= w_pchg_eff;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Message buffer, byte pointer and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= 8'h00;
            end
            r_ptr        <= '0;
            r_have_msg   <= 1'b0;
            r_slave_data <= 8'h00;
            r_len        <= 8'h00;
        end else begin
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= w_buf_nxt[i];
            end
            r_ptr        <= w_ptr_nxt;
            r_have_msg   <= w_have_nxt;
            r_slave_data <= w_data_nxt;
            r_len        <= w_len_nxt;
        end
    end

    assign have_msg   = r_have_msg;
    assign slave_data = r_slave_data;
    assign len        = r_len;

endmodule
